multiplex_7seg: RTL and testbench
=================================

MULTIPLEX_7SEG -- requirements
Module: multiplex_7seg

Interface
REQ-001 SHALL have parameter DIV, default 50000, clock cycles per digit slot (legal range DIV >= 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 50, frames per blink half-period (legal range >= 1).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 = seg and an driven active-low.
REQ-004 SHALL have port count  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port unite  input  4  BCD units digit from the display-conversion stage.
REQ-007 SHALL have port dizaine  input  4  BCD tens digit.
REQ-008 SHALL have port centaine  input  4  BCD hundreds digit.
REQ-009 SHALL have port blank_zeros  input  1  1 = suppress leading zeros.
REQ-010 SHALL have port blink  input  1  1 = flash the whole display.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port an  output  3  digit enables; an[0] = units, an[1] = tens, an[2] = hundreds.

Function
REQ-013 SHALL run a prescaler that counts 0..DIV-1 and wraps to 0; the tick is the cycle where prescaler = DIV-1.
REQ-014 SHALL implement scan FSM states S_U, S_D, S_C.
REQ-015 SHALL advance S_U->S_D->S_C->S_U only on tick and hold the state otherwise.
REQ-016 SHALL define a frame as one full S_U, S_D, S_C cycle, i.e. 3*DIV clock cycles.
REQ-017 SHALL load unite, dizaine and centaine into shadow registers on the tick edge that leaves S_C, so each frame shows one coherent value.
REQ-018 SHALL ignore input changes inside a frame until the next snapshot.
REQ-019 SHALL decode digits with active-high logical patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-020 SHALL decode shadow values 10..15 as dash (40 hex).
REQ-021 SHALL, when blank_zeros=1, blank the hundreds digit if its shadow is 0.
REQ-022 SHALL, when blank_zeros=1, blank the tens digit if both the hundreds and tens shadows are 0.
REQ-023 SHALL never blank the units digit.
REQ-024 SHALL sample blank_zeros combinationally every cycle.
REQ-025 SHALL drive seg = 00 (logical) for a blanked digit; the digit's an stays active.
REQ-026 SHALL drive an as one-hot of the current state: S_U = 001, S_D = 010, S_C = 100.
REQ-027 SHALL force an to all-inactive while prescaler = 0 (one-cycle dead time per slot, anti-ghosting).
REQ-028 SHALL increment a frame counter on each S_C->S_U transition.
REQ-029 SHALL, when the frame counter reaches BLINK_FRAMES-1, wrap it to 0 and toggle blink_phase on the next S_C->S_U transition.
REQ-030 SHALL force an to all-inactive and seg to 00 when blink=1 and blink_phase=1.
REQ-031 SHALL keep the frame counter and blink_phase running while blink=0.
REQ-032 SHALL derive seg and an combinationally from registered state only (prescaler, FSM, shadows, blink_phase) plus blank_zeros and blink.
REQ-033 SHALL, when ACTIVE_LOW=1, invert both seg and an at the ports; an "inactive" level is then 1.

Reset
REQ-034 SHALL, on reset asserted, immediately clear prescaler, frame counter and blink_phase to 0, set state to S_U and set all shadows to 0.
REQ-035 SHALL hold seg and an at inactive levels for the whole time reset is high, including reset asserted mid-slot.
REQ-036 SHALL start the first post-reset slot at prescaler 0, i.e. with the dead-time cycle.
REQ-037 SHALL show shadows = 0 in the first post-reset frame (blank_zeros=1 -> "  0").

Verification (DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=0)
REQ-038 SHALL verify scan timing: release reset, inputs 1/2/3 -> frame 1 shows 0,0,0; from frame 2 an = 000,001,001,001 then 000,010,010,010 then 000,100,100,100, repeating every 12 cycles, with seg = 4F, 5B, 06 in the units, tens and hundreds slots.
REQ-039 SHALL verify leading-zero blanking: hundreds=0, tens=0, units=7, blank_zeros=1 -> units slot seg = 07; tens and hundreds slots seg = 00.
REQ-040 SHALL verify blanking off and dash decode: blank_zeros=0 with the same inputs -> seg 3F in tens and hundreds; units=12 -> units seg = 40.
REQ-041 SHALL verify snapshot coherency: change inputs 6/5/4 -> 9/9/9 during the S_D slot -> current frame keeps showing 4,5,6; next frame shows 9,9,9.
REQ-042 SHALL verify blink: blink=1 -> an = 000 and seg = 00 for 2 frames (24 cycles), then normal for 2 frames, alternating.
REQ-043 SHALL verify mid-operation reset: reset pulsed in S_C at prescaler 2 -> an and seg go inactive without waiting for a clock edge; after release, state = S_U and the hundreds, tens and units shadows are 0.

Source files
------------

// File: rtl/multiplex_7seg.sv
// Three-digit multiplexed 7-segment driver: scans units/tens/hundreds, shows one
// coherent snapshot per frame, with leading-zero blanking, dead time and blinking.
module multiplex_7seg #(
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 50,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       count,
  input  logic       reset,
  input  logic [3:0] unite,
  input  logic [3:0] dizaine,
  input  logic [3:0] centaine,
  input  logic       blank_zeros,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_U = 2'd0,
    S_D = 2'd1,
    S_C = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            phase_q, phase_d;
  logic [3:0]      sh_u_q, sh_u_d;
  logic [3:0]      sh_d_q, sh_d_d;
  logic [3:0]      sh_c_q, sh_c_d;
  logic            tick;

  logic [3:0]      digit;
  logic            digit_blank;
  logic            disp_off;
  logic [6:0]      seg_l;
  logic [2:0]      an_l;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] slot_onehot(input state_t s);
    logic [2:0] oh;
    case (s)
      S_U:     oh = 3'b001;
      S_D:     oh = 3'b010;
      S_C:     oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    state_d = state_q;
    frame_d = frame_q;
    phase_d = phase_q;
    sh_u_d  = sh_u_q;
    sh_d_d  = sh_d_q;
    sh_c_d  = sh_c_q;
    if (tick) begin
      case (state_q)
        S_U: state_d = S_D;
        S_D: state_d = S_C;
        S_C: begin
          // Frame boundary: take the snapshot and advance the blink timebase.
          state_d = S_U;
          sh_u_d  = unite;
          sh_d_d  = dizaine;
          sh_c_d  = centaine;
          if (frame_q == FRAME_MAX) begin
            frame_d = '0;
            phase_d = ~phase_q;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
        default: state_d = S_U;
      endcase
    end
  end

  always_ff @(posedge count or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      state_q <= S_U;
      frame_q <= '0;
      phase_q <= 1'b0;
      sh_u_q  <= '0;
      sh_d_q  <= '0;
      sh_c_q  <= '0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      sh_u_q  <= sh_u_d;
      sh_d_q  <= sh_d_d;
      sh_c_q  <= sh_c_d;
    end
  end

  always_comb begin
    digit       = sh_u_q;
    digit_blank = 1'b0;
    case (state_q)
      S_U: digit = sh_u_q;
      S_D: begin
        digit       = sh_d_q;
        digit_blank = blank_zeros && (sh_c_q == 4'd0) && (sh_d_q == 4'd0);
      end
      S_C: begin
        digit       = sh_c_q;
        digit_blank = blank_zeros && (sh_c_q == 4'd0);
      end
      default: digit = sh_u_q;
    endcase
  end

  // Reset gates the outputs directly so they go dark without waiting for an edge.
  assign disp_off = reset || (blink && phase_q);
  assign seg_l    = (disp_off || digit_blank) ? 7'h00 : seg_decode(digit);
  assign an_l     = (disp_off || (presc_q == '0)) ? 3'b000 : slot_onehot(state_q);

  assign seg = ACTIVE_LOW ? ~seg_l : seg_l;
  assign an  = ACTIVE_LOW ? ~an_l  : an_l;

endmodule

// File: tb/tb_multiplex_7seg.sv
// Directed bench for multiplex_7seg with DIV=4, BLINK_FRAMES=2, active-high outputs.
module tb_multiplex_7seg;

  logic       count;
  logic       reset;
  logic [3:0] unite;
  logic [3:0] dizaine;
  logic [3:0] centaine;
  logic       blank_zeros;
  logic       blink;
  logic [6:0] seg;
  logic [2:0] an;

  int checks;
  int failures;

  logic [2:0] an_pat [0:11];

  multiplex_7seg #(
    .DIV(4),
    .BLINK_FRAMES(2),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .count(count),
    .reset(reset),
    .unite(unite),
    .dizaine(dizaine),
    .centaine(centaine),
    .blank_zeros(blank_zeros),
    .blink(blink),
    .seg(seg),
    .an(an)
  );

  initial count = 1'b0;
  always #5 count = ~count;

  // Leaves the bench 1-2 time units after the edge with reset released, in cycle 0.
  task automatic do_reset;
    reset = 1'b1;
    @(posedge count);
    @(posedge count);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic step;
    @(posedge count);
    #1;
  endtask

  task automatic test_reset;
    centaine = 4'd1; dizaine = 4'd2; unite = 4'd3;
    blank_zeros = 1'b0; blink = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (an !== 3'b000) begin
        failures++;
        $display("FAIL reset_an i=%0d got=%b exp=000", i, an);
      end
      checks++;
      if (seg !== 7'h00) begin
        failures++;
        $display("FAIL reset_seg i=%0d got=%h exp=00", i, seg);
      end
      @(posedge count);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (an !== 3'b000) begin
      failures++;
      $display("FAIL reset_dead_cycle got=%b exp=000", an);
    end
    step();
    checks++;
    if (an !== 3'b001) begin
      failures++;
      $display("FAIL reset_first_slot_an got=%b exp=001", an);
    end
    checks++;
    if (seg !== 7'h3F) begin
      failures++;
      $display("FAIL reset_first_slot_seg got=%h exp=3F", seg);
    end
  endtask

  task automatic test_scan;
    logic [6:0] exp_seg;
    int slot;
    centaine = 4'd1; dizaine = 4'd2; unite = 4'd3;
    blank_zeros = 1'b1; blink = 1'b0;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      if (k > 0) step();
      slot = (k % 12) / 4;
      if (k < 12) exp_seg = (slot == 0) ? 7'h3F : 7'h00;
      else exp_seg = (slot == 0) ? 7'h4F : (slot == 1) ? 7'h5B : 7'h06;
      checks++;
      if (an !== an_pat[k % 12]) begin
        failures++;
        $display("FAIL scan_an k=%0d got=%b exp=%b", k, an, an_pat[k % 12]);
      end
      if (k % 4 != 0) begin
        checks++;
        if (seg !== exp_seg) begin
          failures++;
          $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, exp_seg);
        end
      end
    end
  endtask

  task automatic test_blanking_dash;
    logic [6:0] exp_seg;
    int slot;
    centaine = 4'd0; dizaine = 4'd0; unite = 4'd7;
    blank_zeros = 1'b1; blink = 1'b0;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      if (k > 0) step();
      if (k == 24) begin
        blank_zeros = 1'b0;
        unite = 4'd12;
        #1;
      end
      slot = (k % 12) / 4;
      if (k < 12) exp_seg = (slot == 0) ? 7'h3F : 7'h00;
      else if (k < 24) exp_seg = (slot == 0) ? 7'h07 : 7'h00;
      else if (k < 36) exp_seg = (slot == 0) ? 7'h07 : 7'h3F;
      else exp_seg = (slot == 0) ? 7'h40 : 7'h3F;
      checks++;
      if (an !== an_pat[k % 12]) begin
        failures++;
        $display("FAIL blank_an k=%0d got=%b exp=%b", k, an, an_pat[k % 12]);
      end
      if (k % 4 != 0) begin
        checks++;
        if (seg !== exp_seg) begin
          failures++;
          $display("FAIL blank_seg k=%0d got=%h exp=%h", k, seg, exp_seg);
        end
      end
    end
  endtask

  task automatic test_snapshot;
    logic [6:0] exp_seg;
    int slot;
    centaine = 4'd6; dizaine = 4'd5; unite = 4'd4;
    blank_zeros = 1'b0; blink = 1'b0;
    do_reset();
    for (int k = 0; k < 36; k++) begin
      if (k > 0) step();
      if (k == 17) begin
        centaine = 4'd9; dizaine = 4'd9; unite = 4'd9;
      end
      slot = (k % 12) / 4;
      if (k < 12) exp_seg = 7'h3F;
      else if (k < 24) exp_seg = (slot == 0) ? 7'h66 : (slot == 1) ? 7'h6D : 7'h7D;
      else exp_seg = 7'h6F;
      if (k % 4 != 0) begin
        checks++;
        if (seg !== exp_seg) begin
          failures++;
          $display("FAIL snapshot_seg k=%0d got=%h exp=%h", k, seg, exp_seg);
        end
      end
    end
  endtask

  task automatic test_blink;
    logic [6:0] exp_seg;
    logic [2:0] exp_an;
    logic       dark;
    int slot;
    centaine = 4'd1; dizaine = 4'd2; unite = 4'd3;
    blank_zeros = 1'b1; blink = 1'b1;
    do_reset();
    for (int k = 0; k < 144; k++) begin
      if (k > 0) step();
      if (k == 72) begin
        blink = 1'b0;
        #1;
      end
      if (k == 96) begin
        blink = 1'b1;
        #1;
      end
      slot = (k % 12) / 4;
      dark = blink && ((k / 24) % 2 == 1);
      if (dark) exp_seg = 7'h00;
      else if (k < 12) exp_seg = (slot == 0) ? 7'h3F : 7'h00;
      else exp_seg = (slot == 0) ? 7'h4F : (slot == 1) ? 7'h5B : 7'h06;
      exp_an = dark ? 3'b000 : an_pat[k % 12];
      checks++;
      if (an !== exp_an) begin
        failures++;
        $display("FAIL blink_an k=%0d got=%b exp=%b", k, an, exp_an);
      end
      if (dark || (k % 4 != 0)) begin
        checks++;
        if (seg !== exp_seg) begin
          failures++;
          $display("FAIL blink_seg k=%0d got=%h exp=%h", k, seg, exp_seg);
        end
      end
    end
    blink = 1'b0;
  endtask

  task automatic test_mid_reset;
    centaine = 4'd1; dizaine = 4'd2; unite = 4'd3;
    blank_zeros = 1'b0; blink = 1'b0;
    do_reset();
    for (int k = 1; k <= 22; k++) step();
    checks++;
    if (an !== 3'b100 || seg !== 7'h06) begin
      failures++;
      $display("FAIL midrst_before an=%b seg=%h exp an=100 seg=06", an, seg);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (an !== 3'b000) begin
      failures++;
      $display("FAIL midrst_async_an got=%b exp=000", an);
    end
    checks++;
    if (seg !== 7'h00) begin
      failures++;
      $display("FAIL midrst_async_seg got=%h exp=00", seg);
    end
    @(posedge count);
    #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      checks++;
      if (an !== an_pat[k]) begin
        failures++;
        $display("FAIL midrst_an k=%0d got=%b exp=%b", k, an, an_pat[k]);
      end
      if (k % 4 != 0) begin
        checks++;
        if (seg !== 7'h3F) begin
          failures++;
          $display("FAIL midrst_seg k=%0d got=%h exp=3F", k, seg);
        end
      end
    end
  endtask

  initial begin
    an_pat = '{3'b000, 3'b001, 3'b001, 3'b001,
               3'b000, 3'b010, 3'b010, 3'b010,
               3'b000, 3'b100, 3'b100, 3'b100};
    checks = 0;
    failures = 0;
    reset = 1'b1;
    unite = 4'd0; dizaine = 4'd0; centaine = 4'd0;
    blank_zeros = 1'b0; blink = 1'b0;
    test_reset();
    test_scan();
    test_blanking_dash();
    test_snapshot();
    test_blink();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
